// File: rtl/sram_like_data_slave.sv
// Data-side SRAM-like bus responder: word RAM with byte-lane stores and an in-order
// response FIFO that releases each entry a fixed number of cycles after acceptance.
module sram_like_data_slave #(
    parameter int AW      = 10,
    parameter int LATENCY = 2,
    parameter int OUTST   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int CW = $clog2(OUTST + 1);
    localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;

    logic [31:0]   mem [0:(1 << AW) - 1];
    logic [31:0]   ent_data [0:OUTST-1];
    logic [2:0]    ent_age  [0:OUTST-1];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          accept;
    logic          pop;
    logic [AW-1:0] word_idx;
    logic [3:0]    lane_mask;
    logic          unused_addr_hi;

    // Lanes first..first+n-1, clipped at lane 3 (misaligned sizes are not flagged).
    function automatic logic [3:0] lanes(input logic [1:0] first, input logic [1:0] sz);
        logic [2:0] n;
        logic [2:0] last;
        logic [3:0] m;
        case (sz)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            2'd2:    n = 3'd4;
            default: n = 3'd3;
        endcase
        last = {1'b0, first} + n - 3'd1;
        m    = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) >= {1'b0, first} && 3'(b) <= last) m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign word_idx       = addr[AW+1:2];
    assign unused_addr_hi = ^addr[31:AW+2];
    assign lane_mask      = lanes(addr[1:0], size);

    assign addr_ok = !reset && (count < CW'(OUTST));
    assign data_ok = !reset && (count != '0) && (ent_age[head] >= 3'(LATENCY));
    assign rdata   = data_ok ? ent_data[head] : '0;
    assign accept  = req && addr_ok;
    assign pop     = data_ok;

    // FIFO control: pointers, occupancy and per-entry ages.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < OUTST; i++) ent_age[i] <= '0;
        end else begin
            for (int i = 0; i < OUTST; i++) begin
                if (ent_age[i] < 3'(LATENCY)) ent_age[i] <= ent_age[i] + 3'd1;
            end
            if (accept) begin
                ent_age[tail] <= 3'd1;
                tail          <= next_ptr(tail);
            end
            if (pop) head <= next_ptr(head);
            if (accept && !pop)      count <= count + 1'b1;
            else if (!accept && pop) count <= count - 1'b1;
        end
    end

    // RAM access happens at the accept edge, so ordering follows acceptance order.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_mask[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
                ent_data[tail] <= '0;
            end else begin
                ent_data[tail] <= mem[word_idx];
            end
        end
    end

endmodule

// File: tb/tb_sram_like_data_slave.sv
// Directed bench for sram_like_data_slave: three instances cover LATENCY 2, 3 and 1;
// a monitor logs every response with its cycle number for latency and order checks.
module tb_sram_like_data_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  sel = 2'd0;

    logic        aok0, aok1, aok2;
    logic        dok0, dok1, dok2;
    logic [31:0] rd0, rd1, rd2;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] resp_data [$];
    int          resp_cyc [$];
    int          n_acc = 0;
    int          n_rsp = 0;
    int          max_pend1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_like_data_slave #(.AW(10), .LATENCY(2), .OUTST(2)) u0 (
        .clk(clk), .reset(reset), .req(req && sel == 2'd0), .wr(wr), .size(size),
        .addr(addr), .wdata(wdata), .addr_ok(aok0), .data_ok(dok0), .rdata(rd0)
    );
    sram_like_data_slave #(.AW(10), .LATENCY(3), .OUTST(2)) u1 (
        .clk(clk), .reset(reset), .req(req && sel == 2'd1), .wr(wr), .size(size),
        .addr(addr), .wdata(wdata), .addr_ok(aok1), .data_ok(dok1), .rdata(rd1)
    );
    sram_like_data_slave #(.AW(10), .LATENCY(1), .OUTST(2)) u2 (
        .clk(clk), .reset(reset), .req(req && sel == 2'd2), .wr(wr), .size(size),
        .addr(addr), .wdata(wdata), .addr_ok(aok2), .data_ok(dok2), .rdata(rd2)
    );

    assign addr_ok = (sel == 2'd0) ? aok0 : (sel == 2'd1) ? aok1 : aok2;
    assign data_ok = (sel == 2'd0) ? dok0 : (sel == 2'd1) ? dok1 : dok2;
    assign rdata   = (sel == 2'd0) ? rd0  : (sel == 2'd1) ? rd1  : rd2;

    // Outstanding count during this cycle = accept edges so far minus pops so far.
    always @(negedge clk) begin
        if (reset) begin
            n_acc = 0;
            n_rsp = 0;
        end else begin
            if (sel == 2'd1 && (n_acc - n_rsp) > max_pend1) max_pend1 = n_acc - n_rsp;
            if (req && addr_ok) n_acc++;
            if (data_ok) n_rsp++;
        end
        if (data_ok) begin
            resp_data.push_back(rdata);
            resp_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Holds req until accepted; returns the cycle in which req && addr_ok was seen.
    task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, output int acc);
        bit ok = 1'b0;
        acc   = -1;
        req   = 1'b1;
        wr    = w;
        size  = s;
        addr  = a;
        wdata = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (addr_ok) begin
                ok  = 1'b1;
                acc = cyc;
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        check("accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input int n);
        int i = 0;
        while (resp_data.size() < n && i < 40) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("rsp_count", resp_data.size(), n);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1, t, b;
        int acc [6];
        logic [31:0] pre [3];

        // Reset held 3 cycles with req asserted.
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_addr_ok", 32'(addr_ok), 32'd0);
            check("rst_data_ok", 32'(data_ok), 32'd0);
            check("rst_rdata", rdata, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        check("addr_ok_after_reset", 32'(addr_ok), 32'd1);
        idle(4);
        check("nothing_accepted_in_reset", resp_data.size(), 0);

        // Store then back-to-back load, LATENCY=2.
        b = resp_data.size();
        issue(1'b1, 2'd2, 32'h10, 32'h11223344, a0);
        issue(1'b0, 2'd2, 32'h10, 32'h0, a1);
        check("t2_b2b_accept", a1 - a0, 1);
        wait_rsp(b + 2);
        check("t2_store_lat", resp_cyc[b] - a0, 2);
        check("t2_load_lat", resp_cyc[b+1] - a0, 3);
        check("t2_store_rdata", resp_data[b], 32'h0);
        check("t2_load_rdata", resp_data[b+1], 32'h11223344);

        // Byte lanes, lane clipping and address aliasing.
        b = resp_data.size();
        issue(1'b1, 2'd2, 32'h20, 32'hAABBCCDD, t);
        issue(1'b1, 2'd0, 32'h21, 32'h00005500, t);
        issue(1'b0, 2'd2, 32'h20, 32'h0, t);
        issue(1'b1, 2'd3, 32'h20, 32'h00EEFF99, t);
        issue(1'b0, 2'd2, 32'h20, 32'h0, t);
        issue(1'b1, 2'd2, 32'h22, 32'h12340000, t);
        issue(1'b0, 2'd2, 32'h20, 32'h0, t);
        issue(1'b0, 2'd2, 32'h1020, 32'h0, t);
        wait_rsp(b + 8);
        check("t3_byte_store_rdata", resp_data[b+1], 32'h0);
        check("t3_size0", resp_data[b+2], 32'hAABB55DD);
        check("t3_size3", resp_data[b+4], 32'hAAEEFF99);
        check("t3_size2_clip", resp_data[b+6], 32'h1234FF99);
        check("t3_alias", resp_data[b+7], 32'h1234FF99);

        // Back-pressure with OUTST=2, LATENCY=3.
        idle(2);
        sel = 2'd1;
        b = resp_data.size();
        for (int i = 0; i < 6; i++) issue(1'b1, 2'd2, 32'h40 + 32'(4*i), 32'hC0DE0000 + 32'(i), t);
        wait_rsp(b + 6);
        b = resp_data.size();
        for (int i = 0; i < 6; i++) issue(1'b0, 2'd2, 32'h40 + 32'(4*i), 32'h0, acc[i]);
        wait_rsp(b + 6);
        check("t4_acc1", acc[1] - acc[0], 1);
        check("t4_acc2_bubble", acc[2] - acc[0], 4);
        check("t4_acc3", acc[3] - acc[0], 5);
        check("t4_acc4_bubble", acc[4] - acc[0], 8);
        check("t4_acc5", acc[5] - acc[0], 9);
        for (int i = 0; i < 6; i++) begin
            check("t4_lat", resp_cyc[b+i] - acc[i], 3);
            check("t4_data", resp_data[b+i], 32'hC0DE0000 + 32'(i));
        end
        check("t4_max_outstanding", max_pend1, 2);

        // LATENCY=1, loads every cycle.
        idle(2);
        sel = 2'd2;
        pre[0] = 32'h01234567;
        pre[1] = 32'h89ABCDEF;
        pre[2] = 32'hDEADBEEF;
        b = resp_data.size();
        for (int i = 0; i < 3; i++) issue(1'b1, 2'd2, 32'(4*i), pre[i], t);
        wait_rsp(b + 3);
        b = resp_data.size();
        for (int i = 0; i < 3; i++) issue(1'b0, 2'd2, 32'(4*i), 32'h0, acc[i]);
        wait_rsp(b + 3);
        for (int i = 0; i < 3; i++) begin
            check("t5_acc", acc[i] - acc[0], i);
            check("t5_rsp_cycle", resp_cyc[b+i] - acc[0], i + 1);
            check("t5_data", resp_data[b+i], pre[i]);
        end

        // Reset with two loads pending.
        idle(2);
        sel = 2'd0;
        b = resp_data.size();
        issue(1'b0, 2'd2, 32'h20, 32'h0, t);
        issue(1'b0, 2'd2, 32'h10, 32'h0, t);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_rst_data_ok", 32'(data_ok), 32'd0);
            check("t6_rst_addr_ok", 32'(addr_ok), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(5);
        check("t6_dropped", resp_data.size(), b);
        issue(1'b0, 2'd2, 32'h10, 32'h0, t);
        wait_rsp(b + 1);
        idle(5);
        check("t6_one_rsp", resp_data.size(), b + 1);
        check("t6_data", resp_data[b], 32'h11223344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
